// File: rtl/gates_pkg.sv
// Shared operation encodings for the pipelined bitwise gate network.
package gates_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_COMP = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/gates_op_eval.sv
// Combinational evaluator for the eight gate functions; also exposes the COMP
// intermediate n so the caller can finish COMP in a later stage.
module gates_op_eval
    import gates_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] e_i,
    input  logic [WIDTH-1:0] f_i,
    output logic [WIDTH-1:0] n_o,
    output logic [WIDTH-1:0] r1_o,
    output logic [WIDTH-1:0] r2_o
);

    logic [WIDTH-1:0] n;

    always_comb begin
        n    = (a_i | b_i) ^ ~(c_i & d_i);
        n_o  = n;
        r1_o = '0;
        r2_o = '0;
        case (op_i)
            OP_COMP: begin
                r1_o = ~(e_i | n);
                r2_o = f_i & n;
            end
            OP_AND: begin
                r1_o = a_i & b_i;
                r2_o = c_i & d_i;
            end
            OP_OR: begin
                r1_o = a_i | b_i;
                r2_o = c_i | d_i;
            end
            OP_XOR: begin
                r1_o = a_i ^ b_i;
                r2_o = c_i ^ d_i;
            end
            OP_NAND: begin
                r1_o = ~(a_i & b_i);
                r2_o = ~(c_i & d_i);
            end
            OP_NOR: begin
                r1_o = ~(a_i | b_i);
                r2_o = ~(c_i | d_i);
            end
            OP_XNOR: begin
                r1_o = ~(a_i ^ b_i);
                r2_o = ~(c_i ^ d_i);
            end
            OP_PASS: begin
                r1_o = a_i;
                r2_o = b_i;
            end
            default: begin
                r1_o = '0;
                r2_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/gates_pipe.sv
// Two-stage valid/ready pipeline around gates_op_eval with a wrapping
// completed-transaction counter.
module gates_pipe
    import gates_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  in_op_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [WIDTH-1:0] in_c_i,
    input  logic [WIDTH-1:0] in_d_i,
    input  logic [WIDTH-1:0] in_e_i,
    input  logic [WIDTH-1:0] in_f_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_1_o,
    output logic [WIDTH-1:0] out_2_o,
    output logic             out_zero_o,
    output logic [CNT_W-1:0] txn_count_o
);

    op_e              op;
    logic [WIDTH-1:0] eval_n;
    logic [WIDTH-1:0] eval_r1;
    logic [WIDTH-1:0] eval_r2;

    logic             v1_q, v1_d;
    op_e              op1_q, op1_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [WIDTH-1:0] f1_q, f1_d;

    logic             v2_q, v2_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic             ready2;
    logic             accept;
    logic             emit;
    logic [WIDTH-1:0] fin1;
    logic [WIDTH-1:0] fin2;

    assign op = op_e'(in_op_i);

    gates_op_eval #(
        .WIDTH (WIDTH)
    ) u_eval (
        .op_i (op),
        .a_i  (in_a_i),
        .b_i  (in_b_i),
        .c_i  (in_c_i),
        .d_i  (in_d_i),
        .e_i  (in_e_i),
        .f_i  (in_f_i),
        .n_o  (eval_n),
        .r1_o (eval_r1),
        .r2_o (eval_r2)
    );

    assign ready2     = ~v2_q | out_ready_i;
    assign in_ready_o = ~v1_q | ready2;
    assign accept     = in_valid_i & in_ready_o;
    assign emit       = v2_q & out_ready_i;

    // COMP keeps n plus e/f in stage 1 and is finished here in stage 2.
    always_comb begin
        if (op1_q == OP_COMP) begin
            fin1 = ~(e1_q | x1_q);
            fin2 = f1_q & x1_q;
        end else begin
            fin1 = x1_q;
            fin2 = y1_q;
        end
    end

    always_comb begin
        v1_d  = v1_q;
        op1_d = op1_q;
        x1_d  = x1_q;
        y1_d  = y1_q;
        e1_d  = e1_q;
        f1_d  = f1_q;
        if (in_ready_o) begin
            v1_d = in_valid_i;
        end
        if (accept) begin
            op1_d = op;
            x1_d  = (op == OP_COMP) ? eval_n : eval_r1;
            y1_d  = (op == OP_COMP) ? '0 : eval_r2;
            e1_d  = in_e_i;
            f1_d  = in_f_i;
        end
    end

    always_comb begin
        v2_d   = v2_q;
        o1_d   = o1_q;
        o2_d   = o2_q;
        zero_d = zero_q;
        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                o1_d   = fin1;
                o2_d   = fin2;
                zero_d = (fin1 == '0) && (fin2 == '0);
            end
        end
    end

    always_comb begin
        txn_d = txn_q;
        if (emit) begin
            txn_d = txn_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            op1_q  <= OP_COMP;
            x1_q   <= '0;
            y1_q   <= '0;
            e1_q   <= '0;
            f1_q   <= '0;
            v2_q   <= 1'b0;
            o1_q   <= '0;
            o2_q   <= '0;
            zero_q <= 1'b0;
            txn_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            op1_q  <= op1_d;
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            e1_q   <= e1_d;
            f1_q   <= f1_d;
            v2_q   <= v2_d;
            o1_q   <= o1_d;
            o2_q   <= o2_d;
            zero_q <= zero_d;
            txn_q  <= txn_d;
        end
    end

    assign out_valid_o = v2_q;
    assign out_1_o     = o1_q;
    assign out_2_o     = o2_q;
    assign out_zero_o  = zero_q;
    assign txn_count_o = txn_q;

endmodule

// File: tb/tb_gates_pipe.sv
// Bench for gates_pipe: directed steps plus random traffic checked against a
// queue-based reference model; a CNT_W=2 twin shares the inputs to check wrap.
module tb_gates_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   in_op = 3'd0;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0;

    logic         in_ready, out_valid, out_zero;
    logic [W-1:0] out_1, out_2;
    logic [15:0]  txn_count;
    logic         in_ready2, out_valid2, out_zero2;
    logic [W-1:0] out_1_2, out_2_2;
    logic [1:0]   txn_count2;

    always #5 clk = ~clk;

    gates_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk (clk), .rst (rst),
        .in_valid_i (in_valid), .in_ready_o (in_ready), .in_op_i (in_op),
        .in_a_i (a), .in_b_i (b), .in_c_i (c), .in_d_i (d), .in_e_i (e), .in_f_i (f),
        .out_valid_o (out_valid), .out_ready_i (out_ready),
        .out_1_o (out_1), .out_2_o (out_2), .out_zero_o (out_zero),
        .txn_count_o (txn_count)
    );

    gates_pipe #(.WIDTH(W), .CNT_W(2)) u_dut2 (
        .clk (clk), .rst (rst),
        .in_valid_i (in_valid), .in_ready_o (in_ready2), .in_op_i (in_op),
        .in_a_i (a), .in_b_i (b), .in_c_i (c), .in_d_i (d), .in_e_i (e), .in_f_i (f),
        .out_valid_o (out_valid2), .out_ready_i (out_ready),
        .out_1_o (out_1_2), .out_2_o (out_2_2), .out_zero_o (out_zero2),
        .txn_count_o (txn_count2)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [2*W:0] exp_q[$];   // {out_1, out_2, out_zero} in issue order
    int unsigned  model_cnt = 0;
    int unsigned  emit_cnt = 0;
    bit           last_acc = 0;
    bit           stall_prev = 0;
    logic [W-1:0] held1, held2;
    logic         held_z;

    function automatic logic [2*W:0] ref_op(input logic [2:0] op,
                                            input logic [W-1:0] ra, rb, rc, rd, re, rf);
        logic [W-1:0] n, o1, o2;
        n = (ra | rb) ^ ~(rc & rd);
        case (op)
            3'd0: begin o1 = ~(re | n); o2 = rf & n; end
            3'd1: begin o1 = ra & rb; o2 = rc & rd; end
            3'd2: begin o1 = ra | rb; o2 = rc | rd; end
            3'd3: begin o1 = ra ^ rb; o2 = rc ^ rd; end
            3'd4: begin o1 = ~(ra & rb); o2 = ~(rc & rd); end
            3'd5: begin o1 = ~(ra | rb); o2 = ~(rc | rd); end
            3'd6: begin o1 = ~(ra ^ rb); o2 = ~(rc ^ rd); end
            default: begin o1 = ra; o2 = rb; end
        endcase
        return {o1, o2, (o1 == 0 && o2 == 0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] op,
                         input logic [W-1:0] na, nb, nc, nd, ne, nf);
        in_valid = v; in_op = op;
        a = na; b = nb; c = nc; d = nd; e = ne; f = nf;
    endtask

    task automatic new_bundle(input bit v);
        drive(v, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), W'($urandom), W'($urandom));
    endtask

    // One clock: checks at the falling edge, model update, then counters after the edge.
    task automatic cycle();
        logic [2*W:0] exp;
        bit acc, emit;
        @(negedge clk);
        chk("in_ready", in_ready, (out_ready || exp_q.size() < 2));
        chk("in_ready_w2", in_ready2, (out_ready || exp_q.size() < 2));
        if (exp_q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_out_1", out_1, held1);
            chk("stall_out_2", out_2, held2);
            chk("stall_zero", out_zero, held_z);
        end
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (emit) begin
            if (exp_q.size() == 0) begin
                chk("spurious_emit", 1'b1, 1'b0);
            end else begin
                exp = exp_q.pop_front();
                chk("out_1", out_1, exp[2*W:W+1]);
                chk("out_2", out_2, exp[W:1]);
                chk("out_zero", out_zero, exp[0]);
                chk("out_1_w2", out_1_2, exp[2*W:W+1]);
                chk("out_valid_w2", out_valid2, 1'b1);
                chk("out_2_w2", out_2_2, exp[W:1]);
                chk("out_zero_w2", out_zero2, exp[0]);
            end
            model_cnt++;
            emit_cnt++;
        end
        if (acc) exp_q.push_back(ref_op(in_op, a, b, c, d, e, f));
        last_acc   = acc;
        stall_prev = out_valid && !out_ready;
        held1 = out_1; held2 = out_2; held_z = out_zero;
        @(posedge clk);
        #1;
        chk("txn_count", txn_count, model_cnt[15:0]);
        chk("txn_count_w2", txn_count2, model_cnt[1:0]);
    endtask

    // Asserts reset immediately (asynchronously), checks reset values, releases away from an edge.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_1", out_1, 0);
        chk("rst_out_2", out_2, 0);
        chk("rst_out_zero", out_zero, 1'b0);
        chk("rst_txn", txn_count, 0);
        chk("rst_txn_w2", txn_count2, 0);
        exp_q.delete();
        model_cnt = 0; last_acc = 0; stall_prev = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int base;
        int guard;
        // Reset
        #2;
        do_reset();

        // COMP with latency check
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 8'h0F, 8'h30, 8'hFF, 8'h0F, 8'h00, 8'hFF);
        cycle();
        in_valid = 1'b0;
        chk("lat_t1_out_valid", out_valid, 1'b0);
        cycle();
        chk("lat_t2_out_valid", out_valid, 1'b1);
        chk("comp_out_1", out_1, 8'h30);
        chk("comp_out_2", out_2, 8'hCF);
        cycle();
        chk("comp_txn", txn_count, 1);

        // Back-to-back AND, OR, XOR, PASS: four emits in four consecutive cycles
        base = int'(emit_cnt);
        drive(1'b1, 3'd1, 8'hAA, 8'h55, 8'hF0, 8'h3C, 8'h00, 8'h00); cycle();
        drive(1'b1, 3'd2, 8'hAA, 8'h55, 8'hF0, 8'h3C, 8'h00, 8'h00); cycle();
        drive(1'b1, 3'd3, 8'hAA, 8'h55, 8'hF0, 8'h3C, 8'h00, 8'h00); cycle();
        drive(1'b1, 3'd7, 8'hAA, 8'h55, 8'hF0, 8'h3C, 8'h00, 8'h00); cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("stream_emits", emit_cnt - base, 4);

        // Backpressure: 5 stalled cycles while streaming
        out_ready = 1'b0;
        new_bundle(1'b1);
        for (int i = 0; i < 5; i++) begin
            if (last_acc) new_bundle(1'b1);
            cycle();
        end
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_held", exp_q.size(), 2);
        out_ready = 1'b1;
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("bp_drained", exp_q.size(), 0);

        // NAND all-ones gives a zero result
        drive(1'b1, 3'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("nand_out_valid", out_valid, 1'b1);
        chk("nand_out_zero", out_zero, 1'b1);
        cycle();

        // Random traffic with random stalls and mixed ops
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) new_bundle($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // Reset with both stages full
        out_ready = 1'b0;
        new_bundle(1'b1);
        guard = 0;
        while (in_ready && guard < 10) begin
            if (last_acc) new_bundle(1'b1);
            cycle();
            guard++;
        end
        chk("full_before_rst", exp_q.size(), 2);
        #2;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Short random tail, then drain
        for (int i = 0; i < 60; i++) begin
            if (!in_valid || last_acc) new_bundle($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        if (!last_acc) begin
            out_ready = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
